// File: rtl/prf_pkg.sv
// Shared types and helpers for the multi-port physical register file.
package prf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } clr_state_t;

    // Upper bound on write ports handled by the match helper
    localparam int PRF_MAX_WR = 32;

    // Number of entries addressed by a DIR_WIDTH-bit index
    function automatic int prf_depth(input int dir_width);
        return 1 << dir_width;
    endfunction

    // Highest write port whose match bit is set, -1 when none match
    function automatic int prf_highest(input logic [PRF_MAX_WR-1:0] match);
        int r;
        r = -1;
        for (int j = 0; j < PRF_MAX_WR; j++)
            if (match[j]) r = j;
        return r;
    endfunction

endpackage

// File: rtl/prf_clear_fsm.sv
// Sweep-clear sequencer: walks entries 1..DEPTH-1 one per cycle, then pulses done.
module prf_clear_fsm
    import prf_pkg::*;
#(
    parameter int DIR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 i_clear_req,
    output logic                 o_busy,
    output logic                 o_clear_done,
    output logic [DIR_WIDTH-1:0] o_sweep_addr,
    output logic                 o_sweep_we
);

    // DEPTH-1 is the all-ones index
    localparam logic [DIR_WIDTH-1:0] LAST = '1;

    clr_state_t           r_state, w_state_nxt;
    logic [DIR_WIDTH-1:0] r_cnt, w_cnt_nxt;

    // State and sweep counter registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        o_busy       = 1'b0;
        o_clear_done = 1'b0;
        o_sweep_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = SWEEP;
                    w_cnt_nxt   = DIR_WIDTH'(1);
                end
            end
            SWEEP: begin
                o_busy     = 1'b1;
                o_sweep_we = 1'b1;
                if (r_cnt == LAST) w_state_nxt = DONE;
                else               w_cnt_nxt   = r_cnt + DIR_WIDTH'(1);
            end
            DONE: begin
                o_busy       = 1'b1;
                o_clear_done = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_sweep_addr = r_cnt;

endmodule

// File: rtl/prf_multiport.sv
// Multi-port physical register file with write bypass, ready scoreboard and sweep clear.
module prf_multiport
    import prf_pkg::*;
#(
    parameter int DIR_WIDTH  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int TAP_ADDR   = 5
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [NUM_RD*DIR_WIDTH-1:0]  rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_ready,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*DIR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         alloc_en,
    input  logic [DIR_WIDTH-1:0]         alloc_addr,
    input  logic                         clear_req,
    output logic                         busy,
    output logic                         clear_done,
    output logic                         wr_conflict,
    output logic [DATA_WIDTH-1:0]        tap_out
);

    localparam int DEPTH = prf_depth(DIR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_ready;
    logic                  r_wr_conflict;
    logic                  w_busy, w_sweep_we, w_conflict;
    logic [DIR_WIDTH-1:0]  w_sweep_addr;

    prf_clear_fsm #(.DIR_WIDTH(DIR_WIDTH)) u_clr (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_clear_req  (clear_req),
        .o_busy       (w_busy),
        .o_clear_done (clear_done),
        .o_sweep_addr (w_sweep_addr),
        .o_sweep_we   (w_sweep_we)
    );

    // Storage update: sweep owns the array while busy; otherwise ports in
    // ascending order so the highest port wins, and alloc last so it wins on ready.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_ready <= '1;
        end else if (w_busy) begin
            if (w_sweep_we) begin
                r_mem[w_sweep_addr]   <= '0;
                r_ready[w_sweep_addr] <= 1'b1;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*DIR_WIDTH +: DIR_WIDTH] != '0)) begin
                    r_mem[wr_addr[j*DIR_WIDTH +: DIR_WIDTH]]   <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                    r_ready[wr_addr[j*DIR_WIDTH +: DIR_WIDTH]] <= 1'b1;
                end
            end
            if (alloc_en && (alloc_addr != '0)) r_ready[alloc_addr] <= 1'b0;
        end
    end

    // Detect two enabled ports targeting the same nonzero entry
    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_en[j] && wr_en[k] &&
                    (wr_addr[j*DIR_WIDTH +: DIR_WIDTH] == wr_addr[k*DIR_WIDTH +: DIR_WIDTH]) &&
                    (wr_addr[j*DIR_WIDTH +: DIR_WIDTH] != '0))
                    w_conflict = 1'b1;
            end
        end
        if (w_busy) w_conflict = 1'b0;
    end

    // Conflict flag lives for exactly the cycle after the collision
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_wr_conflict <= 1'b0;
        else         r_wr_conflict <= w_conflict;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DIR_WIDTH-1:0]  w_ra;
        logic [PRF_MAX_WR-1:0] w_match;
        int                    w_hit;
        logic [DATA_WIDTH-1:0] w_d;
        logic                  w_r;

        assign w_ra = rd_addr[i*DIR_WIDTH +: DIR_WIDTH];

        // Read mux: zero entry, then same-cycle bypass, then stored state
        always_comb begin
            w_match = '0;
            for (int j = 0; j < NUM_WR; j++)
                w_match[j] = wr_en[j] && (wr_addr[j*DIR_WIDTH +: DIR_WIDTH] == w_ra);
            w_hit = prf_highest(w_match);
            if (w_ra == '0) begin
                w_d = '0;
                w_r = 1'b1;
            end else if (!w_busy && (w_hit >= 0)) begin
                w_d = wr_data[w_hit*DATA_WIDTH +: DATA_WIDTH];
                w_r = 1'b1;
            end else begin
                w_d = r_mem[w_ra];
                w_r = r_ready[w_ra];
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_d;
        assign rd_ready[i]                         = w_r;
    end

    assign busy        = w_busy;
    assign wr_conflict = r_wr_conflict;
    assign tap_out     = (TAP_ADDR == 0) ? '0 : r_mem[TAP_ADDR];

endmodule

// File: tb/tb_prf_multiport.sv
// Bench for prf_multiport: directed vector table, sweep/reset sequences, random vs model.
module tb_prf_multiport;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [1:0]  wr_en;
    logic [5:0]  wa [2];
    logic [31:0] wd [2];
    logic [5:0]  ra [4];
    logic        alloc_en, clear_req;
    logic [5:0]  alloc_addr;

    logic [23:0]  p_rd_addr;
    logic [127:0] rd_data;
    logic [3:0]   rd_ready;
    logic [11:0]  p_wr_addr;
    logic [63:0]  p_wr_data;
    logic         busy, clear_done, wr_conflict;
    logic [31:0]  tap_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic s_busy, s_done;

    // Reference state: entry contents, ready bits, sweep position
    // (0 idle, 1..63 entry being cleared this cycle, 64 done cycle)
    logic [31:0] m_mem [64];
    bit          m_rdy [64];
    int          m_sw;
    bit          m_cf;

    assign p_rd_addr = {ra[3], ra[2], ra[1], ra[0]};
    assign p_wr_addr = {wa[1], wa[0]};
    assign p_wr_data = {wd[1], wd[0]};

    always #5 clk = ~clk;

    prf_multiport #(
        .DIR_WIDTH(6), .DATA_WIDTH(32), .NUM_RD(4), .NUM_WR(2), .TAP_ADDR(5)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .rd_addr(p_rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_en(wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
        .wr_conflict(wr_conflict), .tap_out(tap_out)
    );

    typedef struct {
        logic [1:0]  we;
        logic [5:0]  wa0;
        logic [31:0] wd0;
        logic [5:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [5:0]  aa;
        logic [5:0]  ra;
        logic [31:0] ed;
        logic        er;
        logic        ecf;
        logic [31:0] etap;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = '0;
            m_rdy[i] = 1'b1;
        end
        m_sw = 0;
        m_cf = 1'b0;
    endtask

    task automatic model_edge();
        if (!arst_n) begin
            model_reset();
            return;
        end
        if (m_sw != 0) begin
            if (m_sw < 64) begin
                m_mem[m_sw] = '0;
                m_rdy[m_sw] = 1'b1;
            end
            m_sw = (m_sw == 64) ? 0 : m_sw + 1;
            m_cf = 1'b0;
        end else begin
            m_cf = (wr_en == 2'b11) && (wa[0] == wa[1]) && (wa[0] != 0);
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wa[j] != 0) begin
                    m_mem[wa[j]] = wd[j];
                    m_rdy[wa[j]] = 1'b1;
                end
            if (alloc_en && alloc_addr != 0) m_rdy[alloc_addr] = 1'b0;
            if (clear_req) m_sw = 1;
        end
    endtask

    task automatic model_rd(input logic [5:0] a, output logic [31:0] d, output logic r);
        d = m_mem[a];
        r = m_rdy[a];
        if (a == 0) begin
            d = '0;
            r = 1'b1;
        end else if (m_sw == 0) begin
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wa[j] == a) begin
                    d = wd[j];
                    r = 1'b1;
                end
        end
    endtask

    task automatic check_all();
        logic [31:0] d;
        logic r;
        for (int i = 0; i < 4; i++) begin
            model_rd(ra[i], d, r);
            chk($sformatf("rd%0d_data@%0d", i, ra[i]), rd_data[i*32 +: 32], d);
            chk($sformatf("rd%0d_ready@%0d", i, ra[i]), 32'(rd_ready[i]), 32'(r));
        end
        chk("busy", 32'(busy), 32'(m_sw != 0));
        chk("clear_done", 32'(clear_done), 32'(m_sw == 64));
        chk("wr_conflict", 32'(wr_conflict), 32'(m_cf));
        chk("tap_out", tap_out, m_mem[5]);
    endtask

    // Called at a negedge with inputs already driven; ends at the next negedge
    task automatic tick(input bit do_model);
        #1;
        if (do_model) check_all();
        s_busy = busy;
        s_done = clear_done;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en = '0; alloc_en = 1'b0; clear_req = 1'b0; alloc_addr = '0;
        for (int j = 0; j < 2; j++) begin wa[j] = '0; wd[j] = '0; end
    endtask

    task automatic fill_all();
        for (int a = 1; a < 64; a += 2) begin
            wr_en = (a + 1 <= 63) ? 2'b11 : 2'b01;
            wa[0] = 6'(a);     wd[0] = 32'(a);
            wa[1] = 6'(a + 1); wd[1] = 32'(a + 1);
            tick(1);
        end
        wr_en = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy, done_at;

        //            we     wa0  wd0          wa1  wd1          ae    aa   ra   exp_d        er    ecf   etap
        vec[0]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd0,  32'h0,  1'b1, 1'b0, 32'h0};
        vec[1]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd5,  32'h0,  1'b1, 1'b0, 32'h0};
        vec[2]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd63, 32'h0,  1'b1, 1'b0, 32'h0};
        vec[3]  = '{2'b01, 6'd5, 32'hD,       6'd0,  32'h0,  1'b0, 6'd0,  6'd5,  32'hD,  1'b1, 1'b0, 32'h0};
        vec[4]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd5,  32'hD,  1'b1, 1'b0, 32'hD};
        vec[5]  = '{2'b11, 6'd9, 32'h11,      6'd9,  32'h22, 1'b0, 6'd0,  6'd9,  32'h22, 1'b1, 1'b0, 32'hD};
        vec[6]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd9,  32'h22, 1'b1, 1'b1, 32'hD};
        vec[7]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd9,  32'h22, 1'b1, 1'b0, 32'hD};
        vec[8]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b1, 6'd7,  6'd7,  32'h0,  1'b1, 1'b0, 32'hD};
        vec[9]  = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd7,  32'h0,  1'b0, 1'b0, 32'hD};
        vec[10] = '{2'b01, 6'd7, 32'h3,       6'd0,  32'h0,  1'b0, 6'd0,  6'd7,  32'h3,  1'b1, 1'b0, 32'hD};
        vec[11] = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd7,  32'h3,  1'b1, 1'b0, 32'hD};
        vec[12] = '{2'b10, 6'd0, 32'h0,       6'd12, 32'hC5, 1'b1, 6'd12, 6'd12, 32'hC5, 1'b1, 1'b0, 32'hD};
        vec[13] = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd12, 32'hC5, 1'b0, 1'b0, 32'hD};
        vec[14] = '{2'b11, 6'd0, 32'hFF,      6'd0,  32'hFF, 1'b0, 6'd0,  6'd0,  32'h0,  1'b1, 1'b0, 32'hD};
        vec[15] = '{2'b00, 6'd0, 32'h0,       6'd0,  32'h0,  1'b0, 6'd0,  6'd0,  32'h0,  1'b1, 1'b0, 32'hD};

        arst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) ra[i] = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_clear_done", 32'(clear_done), 32'h0);
        chk("reset_wr_conflict", 32'(wr_conflict), 32'h0);
        chk("reset_tap", tap_out, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;

        // Directed vectors, each port reading the same address
        for (int v = 0; v < 16; v++) begin
            wr_en = vec[v].we;
            wa[0] = vec[v].wa0; wd[0] = vec[v].wd0;
            wa[1] = vec[v].wa1; wd[1] = vec[v].wd1;
            alloc_en = vec[v].ae; alloc_addr = vec[v].aa;
            clear_req = 1'b0;
            for (int i = 0; i < 4; i++) ra[i] = vec[v].ra;
            #1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("vec%0d_rd%0d_data", v, i), rd_data[i*32 +: 32], vec[v].ed);
                chk($sformatf("vec%0d_rd%0d_ready", v, i), 32'(rd_ready[i]), 32'(vec[v].er));
            end
            chk($sformatf("vec%0d_wr_conflict", v), 32'(wr_conflict), 32'(vec[v].ecf));
            chk($sformatf("vec%0d_tap", v), tap_out, vec[v].etap);
            tick(0);
        end
        idle_inputs();

        // Full sweep with an ignored write to entry 4 after it has been cleared
        fill_all();
        ra[0] = 6'd4; ra[1] = 6'd1; ra[2] = 6'd63; ra[3] = 6'd5;
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
        nbusy = 0;
        done_at = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin wr_en = 2'b01; wa[0] = 6'd4; wd[0] = 32'h99; end
            else wr_en = '0;
            tick(1);
            if (s_busy) nbusy++;
            if (s_done) done_at = c;
            if (!s_busy) break;
        end
        chk("sweep_busy_cycles", 32'(nbusy), 32'd64);
        chk("sweep_done_cycle", 32'(done_at), 32'd64);
        idle_inputs();
        #1;
        chk("sweep_write_ignored", rd_data[31:0], 32'h0);
        for (int a = 1; a < 64; a += 4) begin
            for (int i = 0; i < 4; i++) ra[i] = (a + i > 63) ? 6'd63 : 6'(a + i);
            tick(1);
        end

        // Reset asserted while the sweep counter is at 20
        fill_all();
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
        for (int c = 1; c < 20; c++) tick(1);
        ra[0] = 6'd21; ra[1] = 6'd40; ra[2] = 6'd63; ra[3] = 6'd5;
        arst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(clear_done), 32'h0);
        chk("midrst_tap", tap_out, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst_rd%0d_data", i), rd_data[i*32 +: 32], 32'h0);
            chk($sformatf("midrst_rd%0d_ready", i), 32'(rd_ready[i]), 32'h1);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Restarted sweep begins at entry 1
        wr_en = 2'b11; wa[0] = 6'd1; wd[0] = 32'hA1; wa[1] = 6'd2; wd[1] = 32'hA2;
        tick(1);
        idle_inputs();
        ra[0] = 6'd1; ra[1] = 6'd2; ra[2] = 6'd3; ra[3] = 6'd63;
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
        tick(1);
        #1;
        chk("restart_entry1_cleared", rd_data[31:0], 32'h0);
        chk("restart_entry2_kept", rd_data[63:32], 32'hA2);
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (!s_busy) break;
        end
        chk("restart_sweep_ends", 32'(s_busy), 32'h0);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            wr_en = 2'($urandom_range(0, 3));
            wa[0] = 6'($urandom_range(0, 15));
            wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : 6'($urandom_range(0, 15));
            wd[0] = $urandom;
            wd[1] = $urandom;
            alloc_en = ($urandom_range(0, 3) == 0);
            alloc_addr = ($urandom_range(0, 1) == 0) ? wa[0] : 6'($urandom_range(0, 15));
            clear_req = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 4; i++)
                ra[i] = ($urandom_range(0, 7) == 0) ? 6'd5 : 6'($urandom_range(0, 15));
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
